// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and defaults for the mdu32 multiply/divide unit
package mdu_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  function automatic logic is_signed_op(input logic [2:0] o);
    return o == OP_MULT || o == OP_DIV;
  endfunction
endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring unsigned divider, one quotient bit per clock
module mdu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [WIDTH:0]   t, diff;
  logic             ge;
  assign t    = {remainder, quotient[WIDTH-1]};
  assign diff = t - {1'b0, d};
  assign ge   = t >= {1'b0, d};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      d         <= '0;
      cnt       <= '0;
      running   <= 1'b0;
      valid     <= 1'b0;
    end else if (start) begin
      quotient  <= dividend;
      remainder <= '0;
      d         <= divisor;
      cnt       <= '0;
      running   <= 1'b1;
      valid     <= 1'b0;
    end else if (running) begin
      remainder <= ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], ge};
      cnt       <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end
endmodule

// File: rtl/mdu32.sv
// mdu32: iterative MIPS multiply/divide unit with HI/LO; MDU_FAST_MUL_EN selects a single-cycle multiplier
module mdu32 import mdu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t             state, nstate;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand, ma, mb, dv_q, dv_r, q_s, r_s;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH:0]     sum;
  logic               neg_q, neg_r, is_div, dz, accept, sgn, fin, dv_valid;
  assign busy   = state != IDLE;
  assign accept = start && !busy;
  assign sgn    = is_signed_op(op);
  assign ma     = (sgn && read_data_1[WIDTH-1]) ? -read_data_1 : read_data_1;
  assign mb     = (sgn && read_data_2[WIDTH-1]) ? -read_data_2 : read_data_2;
  assign sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? mcand : '0};
  assign fin    = state == FIX && (!is_div || dv_valid);
  assign prod_s = neg_q ? -prod : prod;
  // a zero divisor yields all-ones regardless of sign, so the quotient is never negated
  assign q_s    = dz ? '1 : neg_q ? -dv_q : dv_q;
  assign r_s    = neg_r ? -dv_r : dv_r;
`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_p;
  assign fast_p = (2*WIDTH)'(ma) * (2*WIDTH)'(mb);
`endif
  mdu_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clock(clock), .reset(reset),
    .start(accept && op[2:1] == 2'b01),
    .dividend(ma), .divisor(mb),
    .quotient(dv_q), .remainder(dv_r), .valid(dv_valid)
  );
  always_comb begin
    nstate = state;
    if (state == IDLE && accept && !op[2])
`ifdef MDU_FAST_MUL_EN
      nstate = op[1] ? RUN : FIX;
`else
      nstate = RUN;
`endif
    else if (state == RUN && cnt == CNT_W'(WIDTH - 1))
      nstate = FIX;
    else if (fin)
      nstate = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= nstate;
      done  <= 1'b0;
      if (accept && op == OP_MTHI) begin
        hi   <= read_data_1;
        done <= 1'b1;
      end
      if (accept && op == OP_MTLO) begin
        lo   <= read_data_1;
        done <= 1'b1;
      end
      if (accept && !op[2]) begin
        cnt    <= '0;
        mcand  <= ma;
`ifdef MDU_FAST_MUL_EN
        prod   <= op[1] ? {{WIDTH{1'b0}}, mb} : fast_p;
`else
        prod   <= {{WIDTH{1'b0}}, mb};
`endif
        neg_q  <= sgn && (read_data_1[WIDTH-1] ^ read_data_2[WIDTH-1]);
        neg_r  <= sgn && read_data_1[WIDTH-1];
        is_div <= op[1];
        dz     <= op[1] && read_data_2 == '0;
      end
      if (state == RUN) begin
        cnt  <= cnt + 1'b1;
        prod <= {sum, prod[WIDTH-1:1]};
      end
      if (fin) begin
        hi   <= is_div ? r_s : prod_s[2*WIDTH-1:WIDTH];
        lo   <= is_div ? q_s : prod_s[WIDTH-1:0];
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_mdu32.sv
// tb_mdu32: directed self-checking bench for mdu32
module tb_mdu32;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd7;
  logic [31:0] read_data_1 = '0, read_data_2 = '0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_chk = 0, n_fail = 0;
`ifdef MDU_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  mdu32 dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy) bc++;
      if (done) break;
      @(posedge clock);
      #1 cyc++;
    end
  endtask
  task automatic accept_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    start = 1'b1;
    op = o;
    read_data_1 = a;
    read_data_2 = b;
    @(posedge clock);
    #1 start = 1'b0;
    read_data_1 = $urandom;
    read_data_2 = $urandom;
  endtask
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input int elat);
    int cyc, bc;
    accept_op(o, a, b);
    wait_done(cyc, bc);
    check({tag, "_lat"}, cyc, elat);
    check({tag, "_busy"}, bc, elat);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    @(posedge clock);
    #1 check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int cyc, bc;
    repeat (2) @(posedge clock);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    @(negedge clock) reset = 1'b0;
    run("mult", 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, ML);
    run("multu", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML);
    run("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("div_7_m2", 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33);
    run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33);
    run("divu_z", 3'd3, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 33);
    run("div_z", 3'd2, 32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 33);
    run("mthi", 3'd4, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'hFFFFFFFF, 0);
    run("mtlo", 3'd5, 32'h5A5A5A5A, 32'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    accept_op(3'd6, 32'h11111111, 32'h22222222);
    check("nop_done", {31'd0, done}, 0);
    check("nop_busy", {31'd0, busy}, 0);
    @(posedge clock);
    #1 check("nop_done2", {31'd0, done}, 0);
    check("nop_hi", hi, 32'hA5A5A5A5);
    check("nop_lo", lo, 32'h5A5A5A5A);
    accept_op(3'd3, 32'd100, 32'd7);
    repeat (10) begin
      @(posedge clock);
      #1;
    end
    start = 1'b1;
    op = 3'd0;
    read_data_1 = 32'd5;
    read_data_2 = 32'd6;
    @(posedge clock);
    #1 start = 1'b0;
    check("ign_busy", {31'd0, busy}, 1);
    wait_done(cyc, bc);
    check("ign_lat", cyc + 11, 33);
    check("ign_hi", hi, 32'd2);
    check("ign_lo", lo, 32'd14);
    accept_op(3'd2, 32'd1000, 32'd3);
    repeat (15) begin
      @(posedge clock);
      #1;
    end
    check("mid_busy", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_hi", hi, 0);
    check("rst_mid_lo", lo, 0);
    check("rst_mid_done", {31'd0, done}, 0);
    @(negedge clock) reset = 1'b0;
    run("multu_3x4", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, ML);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
